faims_bridge_driver: RTL and testbench

//  Parametrised FAIMS HV-switch and coil H-bridge sequencer that generates one FAIMS pulse per period.
//  The coil is driven only in the second half of each period, away from the FAIMS edges.

---
 rtl/faims_bridge_if.sv | 43 ++++
 rtl/faims_bridge_driver.sv | 194 +++++++++++++++++++
 tb/tb_faims_bridge_driver.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/faims_bridge_if.sv
// faims_bridge_if: signal bundle between the register-file side and the FAIMS/H-bridge sequencer.
//   master : register-file side (drives enable, parameter set and load strobe)
//   slave  : sequencer side (drives FAIMS switches, H-bridge gates, period strobe, fault)
// Signals:
//   enable        run request; low forces idle and drops every drive
//   par_period    period P in clock cycles
//   par_pulse_len FAIMS high time L in cycles
//   par_work      coil on-time W in cycles
//   par_dead      dead-time D in cycles (only used when FAIMS_DEADTIME_EN is defined)
//   par_load      single-cycle strobe capturing par_* into the shadow set
//   faims_up/faims_down, coil_au/coil_ad/coil_bu/coil_bd  gate-driver pins
//   period_start  single-cycle pulse at the first cycle of every period
//   fault         sticky parameter fault
interface faims_bridge_if #(
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned WORK_W   = 8,
  parameter int unsigned DEAD_W   = 4
);
  logic                enable;
  logic [PERIOD_W-1:0] par_period;
  logic [PERIOD_W-1:0] par_pulse_len;
  logic [WORK_W-1:0]   par_work;
  logic [DEAD_W-1:0]   par_dead;
  logic                par_load;
  logic                faims_up;
  logic                faims_down;
  logic                coil_au;
  logic                coil_ad;
  logic                coil_bu;
  logic                coil_bd;
  logic                period_start;
  logic                fault;

  modport master (
    output enable, par_period, par_pulse_len, par_work, par_dead, par_load,
    input  faims_up, faims_down, coil_au, coil_ad, coil_bu, coil_bd, period_start, fault
  );

  modport slave (
    input  enable, par_period, par_pulse_len, par_work, par_dead, par_load,
    output faims_up, faims_down, coil_au, coil_ad, coil_bu, coil_bd, period_start, fault
  );
endinterface

// File: rtl/faims_bridge_driver.sv
// faims_bridge_driver: FAIMS HV-switch and coil H-bridge sequencer.
// One FAIMS pulse per period; the coil is driven only in the second half of the period and its
// polarity alternates every period. Parameters are reloaded through a shadow set applied at the
// period wrap, checked against a 50 % duty limit, and an invalid set latches a sticky fault.
// Optional dead-time is compiled in with the macro FAIMS_DEADTIME_EN.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  faims_bridge_if slave modport (enable, parameters, load strobe, drive pins, fault)
module faims_bridge_driver #(
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned WORK_W   = 8,
  parameter int unsigned DEAD_W   = 4
) (
  input logic           clk,
  input logic           rst,
  faims_bridge_if.slave bus
);

  // One spare bit so H+D+W and L+D never overflow at the maximum period.
  localparam int unsigned CntW = PERIOD_W + 1;
  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic [PERIOD_W-1:0] p;
    logic [PERIOD_W-1:0] l;
    logic [WORK_W-1:0]   w;
`ifdef FAIMS_DEADTIME_EN
    logic [DEAD_W-1:0]   d;
`endif
  } par_t;

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   mode_q, mode_d;
  logic   pending_q, pending_d;
  par_t   act_q, act_d;
  par_t   shadow_q, shadow_d;
  par_t   in_set;

  logic up_q, down_q, drv_a_q, drv_b_q, start_q, fault_q;
  logic up_d, down_d, coil_d, start_d, run_d;
  cnt_t half, len, work;
`ifdef FAIMS_DEADTIME_EN
  cnt_t dead;
`else
  logic unused_dead;
  assign unused_dead = ^bus.par_dead;
`endif

  function automatic logic set_valid(par_t s);
    cnt_t h;
    logic ok;
    h  = cnt_t'(s.p >> 1);
    ok = (cnt_t'(s.p) >= cnt_t'(4)) && (s.l != '0) && (cnt_t'(s.l) <= h) && (cnt_t'(s.w) <= h);
`ifdef FAIMS_DEADTIME_EN
    ok = ok && (cnt_t'(s.l) > cnt_t'(s.d)) && ((cnt_t'(s.w) + cnt_t'(s.d)) <= h);
`endif
    return ok;
  endfunction

  always_comb begin
    in_set   = '0;
    in_set.p = bus.par_period;
    in_set.l = bus.par_pulse_len;
    in_set.w = bus.par_work;
`ifdef FAIMS_DEADTIME_EN
    in_set.d = bus.par_dead;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    act_d     = act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    // A load always lands in the shadow; a load on the wrap cycle stays pending for the next wrap.
    if (bus.par_load) begin
      shadow_d  = in_set;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.enable) begin
          if (set_valid(in_set)) begin
            state_d   = StRun;
            mode_d    = 1'b1;
            act_d     = in_set;
            // Active set comes straight from the inputs; an older shadow is stale.
            pending_d = bus.par_load;
          end else begin
            state_d = StFault;
          end
        end
      end
      StRun: begin
        if (cnt_q == cnt_t'(act_q.p) - cnt_t'(1)) begin
          cnt_d  = '0;
          mode_d = ~mode_q;
          if (pending_q) begin
            if (set_valid(shadow_q)) begin
              act_d     = shadow_q;
              pending_d = bus.par_load;
            end else begin
              state_d = StFault;
              mode_d  = mode_q;
            end
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StFault: cnt_d = '0;
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (!bus.enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // Output decode from the next state so the registered pins line up with cnt_q.
  always_comb begin
    half  = cnt_t'(act_d.p >> 1);
    len   = cnt_t'(act_d.l);
    work  = cnt_t'(act_d.w);
    run_d = (state_d == StRun);
`ifdef FAIMS_DEADTIME_EN
    dead   = cnt_t'(act_d.d);
    up_d   = run_d && (cnt_d >= dead) && (cnt_d < len);
    down_d = run_d && (cnt_d >= len + dead);
    coil_d = run_d && (cnt_d >= half + dead) && (cnt_d < half + dead + work);
`else
    up_d   = run_d && (cnt_d < len);
    down_d = run_d && (cnt_d >= len);
    coil_d = run_d && (cnt_d >= half) && (cnt_d < half + work);
`endif
    start_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      act_q     <= '0;
      shadow_q  <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      drv_a_q   <= 1'b0;
      drv_b_q   <= 1'b0;
      start_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      act_q     <= act_d;
      shadow_q  <= shadow_d;
      up_q      <= up_d;
      down_q    <= down_d;
      drv_a_q   <= coil_d && mode_d;
      drv_b_q   <= coil_d && !mode_d;
      start_q   <= start_d;
      fault_q   <= (state_d == StFault);
    end
  end

  // Dropping enable releases the pins in the same cycle; enable is a synchronous input, so the
  // gated pins still only change right after a clock edge.
  assign bus.faims_up     = up_q    & bus.enable;
  assign bus.faims_down   = down_q  & bus.enable;
  assign bus.coil_au      = drv_a_q & bus.enable;
  assign bus.coil_bd      = drv_a_q & bus.enable;
  assign bus.coil_ad      = drv_b_q & bus.enable;
  assign bus.coil_bu      = drv_b_q & bus.enable;
  assign bus.period_start = start_q & bus.enable;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_faims_bridge_driver.sv
// tb_faims_bridge_driver: directed scenarios plus randomized traffic, every cycle compared with
// a behavioural model of the period/phase rules. Build with +define+FAIMS_DEADTIME_EN to cover
// the dead-time variant.
module tb_faims_bridge_driver;
  localparam int unsigned PW = 10;
  localparam int unsigned WW = 8;
  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  faims_bridge_if #(.PERIOD_W(PW), .WORK_W(WW), .DEAD_W(DW)) bus ();

  faims_bridge_driver #(.PERIOD_W(PW), .WORK_W(WW), .DEAD_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: running/faulted flags, phase within the period, polarity, parameter sets.
  bit m_run, m_flt, m_pol, m_pend;
  int m_ph;
  int a_p, a_l, a_w, a_d;
  int s_p, s_l, s_w, s_d;

  function automatic int dead_in();
`ifdef FAIMS_DEADTIME_EN
    return int'(bus.par_dead);
`else
    return 0;
`endif
  endfunction

  // With dead-time absent D is 0, and the dead-time rules collapse to the plain ones.
  function automatic bit valid(input int p, input int l, input int w, input int d);
    return (p >= 4) && (l >= 1) && (l <= p / 2) && (w <= p / 2) && (l > d) && (w + d <= p / 2);
  endfunction

  task automatic model_reset();
    m_run = 0; m_flt = 0; m_pol = 0; m_pend = 0; m_ph = 0;
    a_p = 0; a_l = 0; a_w = 0; a_d = 0;
    s_p = 0; s_l = 0; s_w = 0; s_d = 0;
  endtask

  task automatic model_step();
    int ip, il, iw, id, op, ol, ow, od;
    bit ld, opend;
    ip = int'(bus.par_period); il = int'(bus.par_pulse_len); iw = int'(bus.par_work);
    id = dead_in(); ld = bus.par_load;
    op = s_p; ol = s_l; ow = s_w; od = s_d; opend = m_pend;
    if (ld) begin
      s_p = ip; s_l = il; s_w = iw; s_d = id; m_pend = 1;
    end
    if (!bus.enable) begin
      m_run = 0; m_flt = 0; m_ph = 0;
      return;
    end
    if (m_flt) return;
    if (!m_run) begin
      if (valid(ip, il, iw, id)) begin
        m_run = 1; m_ph = 0; m_pol = 1; m_pend = ld;
        a_p = ip; a_l = il; a_w = iw; a_d = id;
      end else begin
        m_flt = 1;
      end
      return;
    end
    if (m_ph < a_p - 1) begin
      m_ph++;
      return;
    end
    if (opend) begin
      if (!valid(op, ol, ow, od)) begin
        m_run = 0; m_flt = 1; m_ph = 0;
        return;
      end
      a_p = op; a_l = ol; a_w = ow; a_d = od; m_pend = ld;
    end
    m_ph = 0;
    m_pol = !m_pol;
  endtask

  // {up, down, au, ad, bu, bd, period_start, fault}
  function automatic logic [7:0] model_outs();
    int h;
    logic up, dn, co, st;
    logic [6:0] drv;
    h = a_p / 2;
    up = 0; dn = 0; co = 0; st = 0;
    if (m_run) begin
      up = (m_ph >= a_d) && (m_ph < a_l);
      dn = (m_ph >= a_l + a_d);
      co = (m_ph >= h + a_d) && (m_ph < h + a_d + a_w);
      st = (m_ph == 0);
    end
    drv = {up, dn, co & m_pol, co & !m_pol, co & !m_pol, co & m_pol, st};
    if (!bus.enable) drv = '0;
    return {drv, m_flt};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {bus.faims_up, bus.faims_down, bus.coil_au, bus.coil_ad, bus.coil_bu, bus.coil_bd,
            bus.period_start, bus.fault};
  endfunction

  // Called at the falling edge after inputs are set: compare, clock once, advance the model.
  task automatic tick();
    #1;
    check("model", 32'(dut_outs()), 32'(model_outs()));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_pars(input int p, input int l, input int w, input int d);
    bus.par_period = PW'(p); bus.par_pulse_len = PW'(l); bus.par_work = WW'(w);
    bus.par_dead = DW'(d);
  endtask

  task automatic rand_pars(input bit want_valid);
    int p, l, w, d, h, dmax;
    p = int'($urandom_range(30, 4)); h = p / 2;
    l = int'($urandom_range(h, 1)); w = int'($urandom_range(h, 0)); d = 0;
`ifdef FAIMS_DEADTIME_EN
    dmax = (l - 1 < h - w) ? l - 1 : h - w;
    d = int'($urandom_range(dmax, 0));
`else
    dmax = 0;
`endif
    if (!want_valid) begin
      case ($urandom_range(3, 0))
        0: l = h + 1;
        1: w = h + 1;
        2: l = 0;
        default: p = 3;
      endcase
    end
    set_pars(p, l, w, d + dmax * 0);
  endtask

  initial begin
    int n, ups;
    rst = 1'b1;
    bus.enable = 1'b0; bus.par_load = 1'b0;
    set_pars(0, 0, 0, 0);
    model_reset();
    #2;
    check("reset_outs", 32'(dut_outs()), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic sequence and alternating coil polarity.
    set_pars(10, 3, 2, 0);
    tick();
    bus.enable = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      check("t1_up", 32'(bus.faims_up), 32'((c % 10) < 3));
      check("t1_down", 32'(bus.faims_down), 32'((c % 10) >= 3));
      check("t1_au", 32'(bus.coil_au), 32'((c % 10) >= 5 && (c % 10) <= 6 && c < 10));
      check("t1_ad", 32'(bus.coil_ad), 32'((c % 10) >= 5 && (c % 10) <= 6 && c >= 10));
      check("t1_start", 32'(bus.period_start), 32'((c % 10) == 0));
      tick();
    end

    // Shadow reload mid-period is applied at the wrap.
    for (int i = 0; i < 4; i++) tick();
    set_pars(12, 4, 2, 0);
    bus.par_load = 1'b1;
    tick();
    bus.par_load = 1'b0;
    n = 0;
    while (!bus.period_start && n < 20) begin tick(); n++; end
    check("t2_wrap_seen", 32'(bus.period_start), 32'h1);
    n = 0; ups = 0;
    do begin ups += int'(bus.faims_up); tick(); n++; end
    while (!bus.period_start && n < 30);
    check("t2_len", 32'(n), 32'd12);
    check("t2_up_len", 32'(ups), 32'd4);

    // Invalid reload faults at the wrap; disable clears it.
    set_pars(10, 6, 2, 0);
    bus.par_load = 1'b1;
    tick();
    bus.par_load = 1'b0;
    n = 0;
    while (!bus.fault && n < 30) begin tick(); n++; end
    check("t3_fault", 32'(bus.fault), 32'h1);
    check("t3_drv", 32'(dut_outs() >> 1), 32'h0);
    tick();
    bus.enable = 1'b0;
    tick();
    check("t3_clear", 32'(bus.fault), 32'h0);

    // Enable drop mid-period, then restart at phase 0 with polarity A.
    set_pars(10, 3, 2, 0);
    bus.enable = 1'b1;
    tick();
    tick();
    bus.enable = 1'b0;
    #1;
    check("t6_drop", 32'(dut_outs() >> 1), 32'h0);
    tick();
    bus.enable = 1'b1;
    tick();
    check("t6_restart", 32'({bus.period_start, bus.faims_up}), 32'h3);
    for (int i = 0; i < 5; i++) tick();
    check("t6_mode_a", 32'({bus.coil_au, bus.coil_bd, bus.coil_ad}), 32'h6);

    // Asynchronous reset with the coil on.
    rst = 1'b1;
    #1;
    check("t4_async", 32'(dut_outs()), 32'h0);
    model_reset();
    @(negedge clk);
`ifdef FAIMS_DEADTIME_EN
    set_pars(10, 3, 2, 1);
`endif
    rst = 1'b0;
    #1;
    check("t4_idle", 32'(dut_outs()), 32'h0);
    tick();

`ifdef FAIMS_DEADTIME_EN
    for (int c = 0; c < 10; c++) begin
      check("t5_up", 32'(bus.faims_up), 32'(c >= 1 && c <= 2));
      check("t5_down", 32'(bus.faims_down), 32'(c >= 4));
      check("t5_coil", 32'(bus.coil_au), 32'(c >= 6 && c <= 7));
      tick();
    end
    bus.enable = 1'b0;
    tick();
    set_pars(10, 3, 2, 3);
    bus.enable = 1'b1;
    tick();
    check("t5_dead_fault", 32'(bus.fault), 32'h1);
`endif

    // Maximum period: counters must wrap cleanly.
    bus.enable = 1'b0;
    tick();
    set_pars(1023, 511, 255, 0);
    bus.enable = 1'b1;
    for (int i = 0; i < 1030; i++) tick();
    check("max_p_phase", 32'(bus.faims_up), 32'h1);

    // Randomized traffic.
    bus.enable = 1'b0;
    rand_pars(1'b1);
    tick();
    for (int i = 0; i < 4000; i++) begin
      if (bus.enable && $urandom_range(149, 0) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(3, 0) == 0) bus.enable = 1'b1;
      if ($urandom_range(15, 0) == 0) begin
        rand_pars($urandom_range(9, 0) != 0);
        bus.par_load = 1'b1;
      end else if ($urandom_range(31, 0) == 0) begin
        rand_pars($urandom_range(4, 0) != 0);
      end
      tick();
      bus.par_load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
